// File: rtl/stream_group_checker.sv
// Checks a stream of digits in groups of N: each group must hold 1..N exactly once.
// Group results are reported for one cycle; GROUPS groups form one board.
//
// state   | meaning
// COLLECT | accepting digits, position 0..N-1 of the current group
// REPORT  | one cycle, group (and possibly board) result presented
module stream_group_checker #(
  parameter int N      = 4,
  parameter int GROUPS = 12,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          clear,
  input  logic          digitValid,
  input  logic [3:0]    digitIn,
  output logic          digitReady,
  output logic          groupDone,
  output logic          groupCorrect,
  output logic          dupError,
  output logic          rangeError,
  output logic          boardDone,
  output logic          boardCorrect,
  output logic [CW-1:0] groupCount
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {COLLECT = 1'b0, REPORT = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [N-1:0]  seen;
  logic [N-1:0]  digit_onehot;
  logic [N-1:0]  seen_nxt;
  logic          dup_flag;
  logic          range_flag;
  logic          dup_nxt;
  logic          range_nxt;
  logic          last_digit;
  logic          group_ok;
  logic          running;

  // An all-zero one-hot means the digit is 0 or above N, i.e. out of range.
  always_comb begin
    digit_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (digitIn == 4'(i + 1)) digit_onehot[i] = 1'b1;
    end
  end

  assign seen_nxt   = seen | digit_onehot;
  assign dup_nxt    = dup_flag | (|(digit_onehot & seen));
  assign range_nxt  = range_flag | (digit_onehot == '0);
  assign last_digit = (pos == PW'(N - 1));
  assign group_ok   = !dup_nxt && !range_nxt && (&seen_nxt);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= COLLECT;
      pos          <= '0;
      seen         <= '0;
      dup_flag     <= 1'b0;
      range_flag   <= 1'b0;
      running      <= 1'b1;
      digitReady   <= 1'b1;
      groupDone    <= 1'b0;
      groupCorrect <= 1'b0;
      dupError     <= 1'b0;
      rangeError   <= 1'b0;
      boardDone    <= 1'b0;
      boardCorrect <= 1'b0;
      groupCount   <= '0;
    end else if (clear) begin
      state      <= COLLECT;
      pos        <= '0;
      seen       <= '0;
      dup_flag   <= 1'b0;
      range_flag <= 1'b0;
      running    <= 1'b1;
      digitReady <= 1'b1;
      groupDone  <= 1'b0;
      boardDone  <= 1'b0;
      groupCount <= '0;
    end else if (state == COLLECT) begin
      if (digitValid) begin
        if (last_digit) begin
          // Group state is wiped on entry to REPORT; no digit can arrive there.
          state        <= REPORT;
          pos          <= '0;
          seen         <= '0;
          dup_flag     <= 1'b0;
          range_flag   <= 1'b0;
          digitReady   <= 1'b0;
          groupDone    <= 1'b1;
          groupCorrect <= group_ok;
          dupError     <= dup_nxt;
          rangeError   <= range_nxt;
          if (groupCount == CW'(GROUPS - 1)) begin
            groupCount   <= '0;
            boardDone    <= 1'b1;
            boardCorrect <= running && group_ok;
            running      <= 1'b1;
          end else begin
            groupCount <= groupCount + 1'b1;
            running    <= running && group_ok;
          end
        end else begin
          pos        <= pos + 1'b1;
          seen       <= seen_nxt;
          dup_flag   <= dup_nxt;
          range_flag <= range_nxt;
        end
      end
    end else begin
      state      <= COLLECT;
      digitReady <= 1'b1;
      groupDone  <= 1'b0;
      boardDone  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_group_checker.sv
// Randomized and directed bench for stream_group_checker (N=4 and N=9 instances)
// against a queue-based group model.
module tb_stream_group_checker;

  localparam int N4 = 4;
  localparam int G4 = 12;
  localparam int N9 = 9;
  localparam int G9 = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, clear;
  logic       dv4, dr4, gd4, gc4, de4, re4, bd4, bc4;
  logic [3:0] di4, gcnt4;
  logic       dv9, dr9, gd9, gc9, de9, re9, bd9, bc9;
  logic [3:0] di9;
  logic [4:0] gcnt9;

  stream_group_checker #(.N(N4), .GROUPS(G4), .CW(4)) dut4 (
    .clk(clk), .rstN(rstN), .clear(clear), .digitValid(dv4), .digitIn(di4),
    .digitReady(dr4), .groupDone(gd4), .groupCorrect(gc4), .dupError(de4),
    .rangeError(re4), .boardDone(bd4), .boardCorrect(bc4), .groupCount(gcnt4));

  stream_group_checker #(.N(N9), .GROUPS(G9), .CW(5)) dut9 (
    .clk(clk), .rstN(rstN), .clear(clear), .digitValid(dv9), .digitIn(di9),
    .digitReady(dr9), .groupDone(gd9), .groupCorrect(gc9), .dupError(de9),
    .rangeError(re9), .boardDone(bd9), .boardCorrect(bc9), .groupCount(gcnt9));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model state
  bit         m4_ready, m4_gd, m4_gc, m4_de, m4_re, m4_bd, m4_bc;
  int         m4_cnt;
  logic [3:0] q4[$];
  bit         res4[$];
  bit         m9_ready, m9_gd, m9_gc, m9_de, m9_re;
  int         m9_cnt;
  logic [3:0] q9[$];

  function automatic void eval_group(input logic [3:0] q[$], input int n,
                                     output bit corr, output bit dup, output bit rng);
    int cnt[16];
    foreach (cnt[i]) cnt[i] = 0;
    foreach (q[i]) cnt[q[i]]++;
    rng = (cnt[0] > 0);
    for (int v = n + 1; v < 16; v++) if (cnt[v] > 0) rng = 1;
    dup = 0;
    corr = 1;
    for (int v = 1; v <= n; v++) begin
      if (cnt[v] > 1) dup = 1;
      if (cnt[v] != 1) corr = 0;
    end
    corr = corr && !dup && !rng;
  endfunction

  task automatic model_reset();
    m4_ready = 1; m4_gd = 0; m4_gc = 0; m4_de = 0; m4_re = 0; m4_bd = 0; m4_bc = 0;
    m4_cnt = 0; q4.delete(); res4.delete();
    m9_ready = 1; m9_gd = 0; m9_gc = 0; m9_de = 0; m9_re = 0;
    m9_cnt = 0; q9.delete();
  endtask

  task automatic model_edge(input bit v4, input logic [3:0] d4,
                            input bit v9, input logic [3:0] d9, input bit clr);
    bit c, du, r;
    if (clr) begin
      m4_ready = 1; m4_gd = 0; m4_bd = 0; m4_cnt = 0; q4.delete(); res4.delete();
      m9_ready = 1; m9_gd = 0; m9_cnt = 0; q9.delete();
      return;
    end
    if (!m4_ready) begin
      m4_ready = 1; m4_gd = 0; m4_bd = 0;
    end else if (v4) begin
      q4.push_back(d4);
      if (q4.size() == N4) begin
        eval_group(q4, N4, c, du, r);
        q4.delete();
        m4_gc = c; m4_de = du; m4_re = r; m4_gd = 1; m4_ready = 0;
        res4.push_back(c);
        m4_cnt = res4.size();
        if (res4.size() == G4) begin
          m4_bd = 1;
          m4_bc = 1;
          foreach (res4[i]) m4_bc &= res4[i];
          res4.delete();
          m4_cnt = 0;
        end
      end
    end
    if (!m9_ready) begin
      m9_ready = 1; m9_gd = 0;
    end else if (v9) begin
      q9.push_back(d9);
      if (q9.size() == N9) begin
        eval_group(q9, N9, c, du, r);
        q9.delete();
        m9_gc = c; m9_de = du; m9_re = r; m9_gd = 1; m9_ready = 0;
        m9_cnt = (m9_cnt + 1) % G9;
      end
    end
  endtask

  task automatic check_all();
    chk("ready4", dr4, m4_ready);
    chk("gdone4", gd4, m4_gd);
    chk("gcorr4", gc4, m4_gc);
    chk("dup4", de4, m4_de);
    chk("range4", re4, m4_re);
    chk("bdone4", bd4, m4_bd);
    chk("bcorr4", bc4, m4_bc);
    chk("gcnt4", 32'(gcnt4), 32'(m4_cnt));
    chk("ready9", dr9, m9_ready);
    chk("gdone9", gd9, m9_gd);
    chk("gcorr9", gc9, m9_gc);
    chk("dup9", de9, m9_de);
    chk("range9", re9, m9_re);
    chk("gcnt9", 32'(gcnt9), 32'(m9_cnt));
  endtask

  // Called at a falling edge; drives one cycle and checks after the next rising edge.
  task automatic step(input bit v4, input logic [3:0] d4,
                      input bit v9, input logic [3:0] d9, input bit clr);
    dv4 = v4; di4 = d4; dv9 = v9; di9 = d9; clear = clr;
    @(posedge clk);
    model_edge(v4, d4, v9, d9, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    step(1, a, 0, 0, 0);
    step(1, b, 0, 0, 0);
    step(1, c, 0, 0, 0);
    step(1, d, 0, 0, 0);
  endtask

  task automatic send9(input logic [3:0] g[9]);
    for (int i = 0; i < 9; i++) step(0, 0, 1, g[i], 0);
  endtask

  logic [3:0] g9[9];
  logic [3:0] p4[4];

  task automatic perm4();
    logic [3:0] t;
    int j;
    for (int i = 0; i < 4; i++) p4[i] = 4'(i + 1);
    for (int i = 3; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = p4[i]; p4[i] = p4[j]; p4[j] = t;
    end
  endtask

  initial begin
    logic [3:0] t;
    int j;
    rstN = 0; clear = 0; dv4 = 0; di4 = 0; dv9 = 0; di9 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rstN = 1;
    @(negedge clk);

    // basic correct group, then dup and range groups
    send4(1, 2, 3, 4);
    chk("t1_gdone", gd4, 1);
    chk("t1_gcorr", gc4, 1);
    chk("t1_cnt", 32'(gcnt4), 1);
    step(0, 0, 0, 0, 0);
    send4(2, 2, 3, 4);
    chk("t2_dup", de4, 1);
    chk("t2_gcorr", gc4, 0);
    step(1, 1, 0, 0, 0);
    send4(0, 1, 2, 3);
    chk("t3_range", re4, 1);
    chk("t3_dup", de4, 0);
    step(0, 0, 0, 0, 0);

    // partial group discarded by clear
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    send4(4, 3, 2, 1);
    chk("clr_gcorr", gc4, 1);
    chk("clr_cnt", 32'(gcnt4), 1);
    step(0, 0, 0, 0, 1);

    // two boards with digitValid held high; second has a bad group 7
    for (int b = 0; b < 2; b++) begin
      for (int g = 0; g < G4; g++) begin
        perm4();
        if (b == 1 && g == 6) for (int i = 0; i < 4; i++) p4[i] = 1;
        for (int i = 0; i < 4; i++) step(1, p4[i], 0, 0, 0);
        step(1, 4'($urandom_range(15, 0)), 0, 0, 0);
      end
    end
    step(0, 0, 0, 0, 1);

    // N=9: descending group, then permutations with 10 injected
    for (int i = 0; i < 9; i++) g9[i] = 4'(9 - i);
    send9(g9);
    chk("n9_gcorr", gc9, 1);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 9; i++) g9[i] = 4'(i + 1);
      for (int i = 8; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = g9[i]; g9[i] = g9[j]; g9[j] = t;
      end
      g9[$urandom_range(8, 0)] = 10;
      send9(g9);
      chk("n9_range", re9, 1);
      step(0, 0, 0, 0, 0);
    end

    // random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(3, 0) != 0,
           ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(4, 1)),
           $urandom_range(3, 0) != 0,
           ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(9, 1)),
           $urandom_range(199, 0) == 0);
    end

    // asynchronous reset at position 2, between clock edges
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    #2 rstN = 0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rstN = 1;
    send4(1, 2, 3, 4);
    chk("rst_gcorr", gc4, 1);
    step(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
